// File: rtl/ysyx_22040088_ifu.sv
// ysyx_22040088_ifu -- instruction fetch unit for the single-issue core.
//
// Holds the architectural PC and fetches one 32-bit instruction per PC over a
// valid/ready instruction-memory port. It presents {pc, inst, fault} to decode
// and waits for decode to return the next PC.
//
// Handshake semantics: a transfer happens on a rising edge where valid and ready
// are both high. Once valid is raised, the producer holds valid and its payload
// stable until that edge. The producer never waits for ready before raising
// valid.
//
// Ports:
//   clk, rst                  core clock; synchronous active-high reset
//   imem_req_valid/ready/addr fetch request (addr always equals the PC register)
//   imem_resp_valid/data/err  fetch response (only sampled while waiting for it)
//   out_valid/ready           instruction towards decode
//   out_pc/inst/fault         presented PC, latched instruction, fetch fault
//   nextpc_valid, nextpc      next PC returned by decode
//   fetch_cnt                 instructions delivered to decode (wraps at 2^64)
module ysyx_22040088_ifu #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault,
    input  logic        nextpc_valid,
    input  logic [63:0] nextpc,
    output logic [63:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_DELIVER = 3'd3,
        S_WAITPC  = 3'd4
    } state_e;

    // A misaligned PC is not sent to memory. It is delivered as a faulting nop.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        fault_q, fault_d;
    logic [63:0] cnt_q, cnt_d;
    logic        pc_aligned;

    assign pc_aligned = (pc_q[1:0] == 2'b00);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        inst_d         = inst_q;
        fault_d        = fault_q;
        cnt_d          = cnt_q;
        imem_req_valid = 1'b0;
        out_valid      = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (pc_aligned) begin
                    imem_req_valid = 1'b1;
                    if (imem_req_ready) begin
                        state_d = S_WAIT;
                    end
                end else begin
                    inst_d  = NOP_INST;
                    fault_d = 1'b1;
                    state_d = S_DELIVER;
                end
            end
            S_WAIT: begin
                // The response is only looked at here. A request and its
                // response therefore always land on different edges.
                if (imem_resp_valid) begin
                    inst_d  = imem_resp_data;
                    fault_d = imem_resp_err;
                    state_d = S_DELIVER;
                end
            end
            S_DELIVER: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_d = cnt_q + 64'd1;
                    // Decode normally computes nextpc in the same cycle. If it
                    // does not, the PC is parked until nextpc arrives.
                    if (nextpc_valid) begin
                        pc_d    = nextpc;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_WAITPC;
                    end
                end
            end
            S_WAITPC: begin
                if (nextpc_valid) begin
                    pc_d    = nextpc;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            fault_q <= 1'b0;
            cnt_q   <= 64'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req_addr = pc_q;
    assign out_pc        = pc_q;
    assign out_inst      = inst_q;
    assign out_fault     = fault_q;
    assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// Testbench for ysyx_22040088_ifu.
// The main sequence drives directed scenarios and pushes the expected {pc, inst, fault}
// for every delivery into exp_q. A memory model and a decode model drive the DUT inputs
// on the falling edge. A monitor pops exp_q on each decode handshake and compares.
module tb_ysyx_22040088_ifu;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;
    logic        nextpc_valid;
    logic [63:0] nextpc;
    logic [63:0] fetch_cnt;

    ysyx_22040088_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .out_fault       (out_fault),
        .nextpc_valid    (nextpc_valid),
        .nextpc          (nextpc),
        .fetch_cnt       (fetch_cnt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- shared state ----------------
    int checks   = 0;
    int failures = 0;

    logic [96:0] exp_q[$];        // {pc, inst, fault}

    // memory model knobs / stats
    logic [31:0] mem_data   = 32'h0000_0513;
    logic        mem_err    = 1'b0;
    int          mem_stall  = 0;
    int          mem_delay  = 0;
    logic        force_resp = 1'b0;
    logic        mem_pending = 1'b0;
    int          req_count  = 0;

    // decode model knobs / stats
    int          dec_rdy_wait = 0;
    logic        np_late      = 1'b0;  // 0: nextpc=pc+4 on handshake; 1: park in WAITPC
    logic [63:0] late_pc      = 64'h0;
    int          late_req     = 0;
    int          delivered    = 0;
    int          stall_obs    = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- memory model ----------------
    initial begin
        int   stall_left = 0;
        int   wait_left  = 0;
        logic stalling   = 1'b0;
        logic [63:0] held_addr = 64'h0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        imem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            imem_req_ready  = 1'b0;
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
            imem_resp_err   = 1'b0;
            if (force_resp) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = 32'hdead_beef;
            end
            if (rst) begin
                mem_pending = 1'b0;
                stalling    = 1'b0;
            end else if (mem_pending) begin
                if (wait_left == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_data;
                    imem_resp_err   = mem_err;
                    mem_pending     = 1'b0;
                end else begin
                    wait_left--;
                end
            end else if (imem_req_valid) begin
                check("req_aligned", {126'h0, imem_req_addr[1:0]}, 128'h0);
                if (!stalling) begin
                    stalling   = 1'b1;
                    stall_left = mem_stall;
                    held_addr  = imem_req_addr;
                end else begin
                    check("req_addr_stable", {64'h0, imem_req_addr}, {64'h0, held_addr});
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    imem_req_ready = 1'b1;
                    mem_pending    = 1'b1;
                    wait_left      = mem_delay;
                    stalling       = 1'b0;
                    req_count++;
                end
            end
        end
    end

    // ---------------- decode model ----------------
    initial begin
        int   rdy_left    = 0;
        logic in_delivery = 1'b0;
        int   late_done   = 0;
        out_ready    = 1'b0;
        nextpc_valid = 1'b0;
        nextpc       = 64'h0;
        forever begin
            @(negedge clk);
            out_ready    = 1'b0;
            nextpc_valid = 1'b0;
            nextpc       = 64'h0;
            if (rst) begin
                in_delivery = 1'b0;
                late_done   = late_req;
            end else if (out_valid) begin
                if (!in_delivery) begin
                    in_delivery = 1'b1;
                    rdy_left    = dec_rdy_wait;
                end
                if (rdy_left > 0) begin
                    rdy_left--;
                end else begin
                    out_ready   = 1'b1;
                    in_delivery = 1'b0;
                    if (!np_late) begin
                        nextpc_valid = 1'b1;
                        nextpc       = out_pc + 64'd4;
                    end
                end
            end else if (late_done != late_req) begin
                nextpc_valid = 1'b1;
                nextpc       = late_pc;
                late_done    = late_req;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [63:0] exp_cnt = 64'h0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                exp_cnt = 64'h0;
            end else if (out_valid) begin
                check("fetch_cnt_track", {64'h0, fetch_cnt}, {64'h0, exp_cnt});
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {31'h0, out_pc, out_inst, out_fault}, 128'h0);
                end else begin
                    check("out_data", {31'h0, out_pc, out_inst, out_fault}, {31'h0, exp_q[0]});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        exp_cnt = exp_cnt + 64'd1;
                        delivered++;
                    end else begin
                        stall_obs++;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_state();
        check("rst_req_valid", {127'h0, imem_req_valid}, 128'h0);
        check("rst_out_valid", {127'h0, out_valid}, 128'h0);
        check("rst_req_addr", {64'h0, imem_req_addr}, {64'h0, RESET_PC});
        check("rst_out_pc", {64'h0, out_pc}, {64'h0, RESET_PC});
        check("rst_out_inst", {96'h0, out_inst}, 128'h0);
        check("rst_out_fault", {127'h0, out_fault}, 128'h0);
        check("rst_fetch_cnt", {64'h0, fetch_cnt}, 128'h0);
    endtask

    // Leaves rst high at negedge+1 after one reset edge; caller releases it.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_state();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic kick(input logic [63:0] pc);
        late_pc = pc;
        late_req++;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int req_before;
        int del_before;
        int stall_before;
        rst = 1'b1;

        // A: reset, zero-wait fetch, exact latency, same-cycle nextpc.
        apply_reset();
        exp_q.push_back({RESET_PC, 32'h0000_0513, 1'b0});
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            if (k == 1) begin
                check("lat_req_valid_e1", {127'h0, imem_req_valid}, 128'h1);
                check("lat_req_addr_e1", {64'h0, imem_req_addr}, {64'h0, RESET_PC});
                check("lat_out_valid_e1", {127'h0, out_valid}, 128'h0);
            end else if (k == 2) begin
                check("lat_out_valid_e2", {127'h0, out_valid}, 128'h0);
            end else begin
                check("lat_out_valid_e3", {127'h0, out_valid}, 128'h1);
            end
        end
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!imem_req_valid && n < 10);
        check("next_req_valid", {127'h0, imem_req_valid}, 128'h1);
        check("next_req_addr", {64'h0, imem_req_addr}, {64'h0, 64'h8000_0004});
        check("fetch_cnt_after_1", {64'h0, fetch_cnt}, 128'h1);
        np_late = 1'b1;
        exp_q.push_back({64'h8000_0004, 32'h0000_0513, 1'b0});
        drain("drain_a");
        check("fetch_cnt_a", {64'h0, fetch_cnt}, 128'h2);

        // B: memory stall (ready low 4 cycles) plus 3-cycle response delay.
        apply_reset();
        mem_stall  = 4;
        mem_delay  = 3;
        mem_data   = 32'h0010_0093;
        req_before = req_count;
        del_before = delivered;
        exp_q.push_back({RESET_PC, 32'h0010_0093, 1'b0});
        rst = 1'b0;
        drain("drain_b");
        check("b_one_request", req_count - req_before, 1);
        check("b_one_delivery", delivered - del_before, 1);
        check("fetch_cnt_b", {64'h0, fetch_cnt}, 128'h1);
        mem_stall = 0;
        mem_delay = 0;

        // C: decode holds out_ready low for 5 cycles.
        dec_rdy_wait = 5;
        mem_data     = 32'h0020_8133;
        stall_before = stall_obs;
        exp_q.push_back({64'h8000_0010, 32'h0020_8133, 1'b0});
        kick(64'h8000_0010);
        drain("drain_c");
        check("c_stall_cycles", stall_obs - stall_before, 5);
        check("fetch_cnt_c", {64'h0, fetch_cnt}, 128'h2);
        dec_rdy_wait = 0;

        // D: misaligned nextpc produces a faulting nop without a memory request.
        req_before = req_count;
        exp_q.push_back({64'h8000_0102, 32'h0000_0013, 1'b1});
        kick(64'h8000_0102);
        drain("drain_d");
        check("d_no_request", req_count - req_before, 0);
        check("fetch_cnt_d", {64'h0, fetch_cnt}, 128'h3);

        // E: bus error is delivered and counted once.
        mem_err    = 1'b1;
        mem_data   = 32'hffff_ffff;
        del_before = delivered;
        exp_q.push_back({64'h8000_0200, 32'hffff_ffff, 1'b1});
        kick(64'h8000_0200);
        drain("drain_e");
        check("e_one_delivery", delivered - del_before, 1);
        check("fetch_cnt_e", {64'h0, fetch_cnt}, 128'h4);
        mem_err = 1'b0;

        // F: reset while waiting for a response, with a response pulsed during reset.
        mem_delay = 20;
        kick(64'h8000_0300);
        n = 0;
        while (!mem_pending && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("f_reached_wait", {127'h0, mem_pending}, 128'h1);
        @(posedge clk);
        #2;
        rst        = 1'b1;
        force_resp = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_state();
        force_resp = 1'b0;
        mem_delay  = 0;
        mem_data   = 32'h0000_0513;
        exp_q.push_back({RESET_PC, 32'h0000_0513, 1'b0});
        rst = 1'b0;
        drain("drain_f");
        check("fetch_cnt_f", {64'h0, fetch_cnt}, 128'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
